call_stack: RTL and testbench

Parametrised LIFO call/return stack for the DE0_CV processor datapath. It holds return addresses (default 11 bits, 16 deep) pushed on CALL and popped on RETURN. Compared with the fixed 16×11 stack it adds:
- configurable width and depth;
- occupancy count and full/empty status;
- sticky overflow/underflow error flags;
- same-cycle push+pop (replace top);
- an optional circular-overwrite mode.

---
 rtl/call_stack_if.sv | 29 ++
 rtl/call_stack.sv | 109 ++++++++++
 tb/tb_call_stack.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/call_stack_if.sv
// Signal bundle for call_stack: push/pop strobes, write data and stack status.
// The master side drives the strobes; the stack itself uses the slave side.
interface call_stack_if #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             push;
   logic             pop;
   logic [WIDTH-1:0] data_in;
   logic             clr_err;
   logic [WIDTH-1:0] data_out;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   modport master (
      output push, pop, data_in, clr_err,
      input  data_out, count, empty, full, overflow, underflow
   );

   modport slave (
      input  push, pop, data_in, clr_err,
      output data_out, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/call_stack.sv
// Parametrised LIFO return-address stack with occupancy, full/empty and sticky error flags.
// Define CALL_STACK_CIRCULAR_EN to make a push while full overwrite the oldest entry.
module call_stack #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16
) (
   input logic          clk,
   input logic          reset,
   call_stack_if.slave  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0] top_reg, top_next;
   logic [CW-1:0] count_reg, count_next;
   logic          overflow_reg, overflow_next;
   logic          underflow_reg, underflow_next;

   logic          is_empty, is_full;
   logic          do_push, do_pop, do_replace;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          ovf_evt, unf_evt;

   assign is_empty = (count_reg == '0);
   assign is_full  = (count_reg == FULL_COUNT);

   // Push+pop on a non-empty stack replaces the top; on an empty stack it is a plain push.
   assign do_replace = bus.push & bus.pop & ~is_empty;
   assign do_push    = bus.push & (~bus.pop | is_empty);
   assign do_pop     = bus.pop & ~bus.push;

   always_comb begin
      wr_en      = 1'b0;
      wr_addr    = top_reg;
      top_next   = top_reg;
      count_next = count_reg;
      ovf_evt    = 1'b0;
      unf_evt    = 1'b0;

      if (do_replace) begin
         wr_en   = 1'b1;
         wr_addr = top_reg;
      end else if (do_push) begin
         if (!is_full) begin
            wr_en      = 1'b1;
            wr_addr    = top_reg + AW'(1);
            top_next   = top_reg + AW'(1);
            count_next = count_reg + CW'(1);
         end else begin
            ovf_evt = 1'b1;
`ifdef CALL_STACK_CIRCULAR_EN
            // top+1 is the oldest slot once the ring is full, so it gets overwritten.
            wr_en    = 1'b1;
            wr_addr  = top_reg + AW'(1);
            top_next = top_reg + AW'(1);
`else
            wr_en    = 1'b0;
`endif
         end
      end else if (do_pop) begin
         if (!is_empty) begin
            top_next   = top_reg - AW'(1);
            count_next = count_reg - CW'(1);
         end else begin
            unf_evt = 1'b1;
         end
      end

      // A new error in the same cycle as clr_err keeps the flag set.
      overflow_next  = ovf_evt | (overflow_reg & ~bus.clr_err);
      underflow_next = unf_evt | (underflow_reg & ~bus.clr_err);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         top_reg       <= '1;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         top_reg       <= top_next;
         count_reg     <= count_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   // Storage is not reset; only the pointer and count define which entries are valid.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (reset && wr_en && (wr_addr == AW'(gi))) begin
               mem[gi] <= bus.data_in;
            end
         end
      end
   endgenerate

   assign bus.data_out  = is_empty ? '0 : mem[top_reg];
   assign bus.count     = count_reg;
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.overflow  = overflow_reg;
   assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench: three call_stack instances (11x16, 8x4, 16x32) share one stimulus
// stream and are compared every cycle against a queue-based LIFO model.
module tb_call_stack;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] din = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   call_stack_if #(.WIDTH(11), .DEPTH(16)) b0 ();
   call_stack_if #(.WIDTH(8),  .DEPTH(4))  b1 ();
   call_stack_if #(.WIDTH(16), .DEPTH(32)) b2 ();

   call_stack #(.WIDTH(11), .DEPTH(16)) u0 (.clk(clk), .reset(rst_n), .bus(b0.slave));
   call_stack #(.WIDTH(8),  .DEPTH(4))  u1 (.clk(clk), .reset(rst_n), .bus(b1.slave));
   call_stack #(.WIDTH(16), .DEPTH(32)) u2 (.clk(clk), .reset(rst_n), .bus(b2.slave));

   assign b0.push = push;  assign b0.pop = pop;  assign b0.clr_err = clr;  assign b0.data_in = din[10:0];
   assign b1.push = push;  assign b1.pop = pop;  assign b1.clr_err = clr;  assign b1.data_in = din[7:0];
   assign b2.push = push;  assign b2.pop = pop;  assign b2.clr_err = clr;  assign b2.data_in = din[15:0];

   logic [31:0] dout_obs [3];
   logic [31:0] cnt_obs  [3];
   logic [3:0]  stat_obs [3];   // {empty, full, overflow, underflow}

   assign dout_obs[0] = 32'(b0.data_out);
   assign dout_obs[1] = 32'(b1.data_out);
   assign dout_obs[2] = 32'(b2.data_out);
   assign cnt_obs[0]  = 32'(b0.count);
   assign cnt_obs[1]  = 32'(b1.count);
   assign cnt_obs[2]  = 32'(b2.count);
   assign stat_obs[0] = {b0.empty, b0.full, b0.overflow, b0.underflow};
   assign stat_obs[1] = {b1.empty, b1.full, b1.overflow, b1.underflow};
   assign stat_obs[2] = {b2.empty, b2.full, b2.overflow, b2.underflow};

   // Reference model: one queue per instance, back of queue = top of stack.
   int          dep [3] = '{16, 4, 32};
   int          wid [3] = '{11, 8, 16};
   logic [31:0] mq  [3][$];
   logic        m_ovf [3] = '{1'b0, 1'b0, 1'b0};
   logic        m_unf [3] = '{1'b0, 1'b0, 1'b0};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_step(input logic p, input logic po, input logic [31:0] d,
                             input logic c, input logic r);
      for (int i = 0; i < 3; i++) begin
         int          n;
         logic        oe, ue;
         logic [31:0] dm;
         if (!r) begin
            mq[i].delete();
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
            continue;
         end
         n  = mq[i].size();
         oe = 1'b0;
         ue = 1'b0;
         dm = d & ((32'h1 << wid[i]) - 32'h1);
         if (p && po && n > 0) begin
            mq[i][n-1] = dm;
         end else if (p) begin
            if (n == dep[i]) begin
               oe = 1'b1;
`ifdef CALL_STACK_CIRCULAR_EN
               void'(mq[i].pop_front());
               mq[i].push_back(dm);
`endif
            end else begin
               mq[i].push_back(dm);
            end
         end else if (po) begin
            if (n > 0) void'(mq[i].pop_back());
            else ue = 1'b1;
         end
         m_ovf[i] = oe | (m_ovf[i] & ~c);
         m_unf[i] = ue | (m_unf[i] & ~c);
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         int          n;
         logic [31:0] exp_dout;
         logic [3:0]  exp_stat;
         n        = mq[i].size();
         exp_dout = (n > 0) ? mq[i][n-1] : 32'h0;
         exp_stat = {n == 0, n == dep[i], m_ovf[i], m_unf[i]};
         check($sformatf("dout[%0d]", i), dout_obs[i], exp_dout);
         check($sformatf("count[%0d]", i), cnt_obs[i], 32'(n));
         check($sformatf("status[%0d]", i), 32'(stat_obs[i]), 32'(exp_stat));
      end
   endtask

   // One transaction: apply inputs, clock, update model, then check away from the edge.
   task automatic cycle(input logic p, input logic po, input logic [31:0] d,
                        input logic c, input logic r);
      push  = p;
      pop   = po;
      din   = d;
      clr   = c;
      rst_n = r;
      @(posedge clk);
      model_step(p, po, d, c, r);
      #1;
      cyc++;
      compare_all();
      $display("txn %0d rst_n=%b push=%b pop=%b clr=%b din=%h | count0=%0d dout0=%h ovf0=%b unf0=%b",
               cyc, r, p, po, c, d, cnt_obs[0], dout_obs[0], stat_obs[0][1], stat_obs[0][0]);
   endtask

   initial begin
      #2;
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      check("reset_dout", dout_obs[0], 32'h0);
      check("reset_stat", 32'(stat_obs[0]), 32'h8);

      // Basic LIFO order
      cycle(1, 0, 32'h001, 0, 1);
      cycle(1, 0, 32'h002, 0, 1);
      cycle(1, 0, 32'h003, 0, 1);
      check("tp_count3", cnt_obs[0], 32'd3);
      check("tp_dout3", dout_obs[0], 32'h003);
      cycle(0, 1, 0, 0, 1);
      check("tp_pop1", dout_obs[0], 32'h002);
      cycle(0, 1, 0, 0, 1);
      cycle(0, 1, 0, 0, 1);
      check("tp_empty", 32'(stat_obs[0]), 32'h8);

      // Underflow and clear, then error wins over clr_err
      cycle(0, 1, 0, 0, 1);
      check("tp_unf", 32'(stat_obs[0][0]), 32'h1);
      cycle(0, 0, 0, 1, 1);
      check("tp_unf_clr", 32'(stat_obs[0][0]), 32'h0);
      cycle(0, 1, 0, 1, 1);
      check("tp_unf_win", 32'(stat_obs[0][0]), 32'h1);
      cycle(0, 0, 0, 1, 1);

      // Fill to full, push while full, drain
      for (int k = 0; k < 16; k++) cycle(1, 0, 32'h100 + 32'(k), 0, 1);
      check("tp_full_dout", dout_obs[0], 32'h10F);
      cycle(1, 0, 32'h7FF, 0, 1);
`ifdef CALL_STACK_CIRCULAR_EN
      check("tp_ovf_dout", dout_obs[0], 32'h7FF);
`else
      check("tp_ovf_dout", dout_obs[0], 32'h10F);
`endif
      check("tp_ovf_count", cnt_obs[0], 32'd16);
      check("tp_ovf_flag", 32'(stat_obs[0][1]), 32'h1);
      for (int k = 0; k < 17; k++) cycle(0, 1, 0, 0, 1);
      cycle(0, 0, 0, 1, 1);

      // Replace top, and push+pop on empty
      cycle(1, 0, 32'h0AA, 0, 1);
      cycle(1, 1, 32'h055, 0, 1);
      check("tp_replace", dout_obs[0], 32'h055);
      cycle(0, 1, 0, 0, 1);
      cycle(1, 1, 32'h033, 0, 1);
      check("tp_pp_empty", dout_obs[0], 32'h033);
      cycle(0, 1, 0, 0, 1);

      // Reset mid-sequence discards entries
      for (int k = 0; k < 5; k++) cycle(1, 0, 32'h200 + 32'(k), 0, 1);
      cycle(1, 0, 32'h2FF, 0, 0);
      check("tp_rst_count", cnt_obs[0], 32'd0);
      cycle(1, 0, 32'h321, 0, 1);
      check("tp_rst_push", dout_obs[0], 32'h321);

      // Fill past the deepest instance, then drain past empty
      for (int k = 0; k < 34; k++) cycle(1, 0, $urandom, 0, 1);
      for (int k = 0; k < 35; k++) cycle(0, 1, 0, 0, 1);
      cycle(0, 0, 0, 1, 1);

      // Random traffic, push-biased so the small instances hit full often
      for (int k = 0; k < 400; k++) begin
         logic p, po, c, r;
         p  = ($urandom_range(0, 99) < 55);
         po = ($urandom_range(0, 99) < 40);
         c  = ($urandom_range(0, 99) < 6);
         r  = ($urandom_range(0, 199) != 0);
         cycle(p, po, $urandom, c, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
